// File: rtl/h14tx_island_packetizer.sv
// Data-island packet serializer: slots packets into 32-clock windows with on-the-fly BCH parity.
// Optional macro H14TX_PACKETIZER_OUTREG_EN adds a second register stage on timings_o/ch0/ch1/ch2.
package h14tx_pkg;
    typedef enum logic [2:0] {
        Control            = 3'd0,
        VideoPreamble      = 3'd1,
        VideoGuard         = 3'd2,
        VideoActive        = 3'd3,
        DataIslandPreamble = 3'd4,
        DataIslandGuard    = 3'd5,
        DataIslandActive   = 3'd6
    } period_t;
endpackage

module h14tx_island_packetizer
    import h14tx_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  period_t        timings,
    input  logic           hsync,
    input  logic           vsync,
    input  logic           packet_valid,
    input  logic [23:0]    packet_header,
    input  logic [223:0]   packet_sub,
    output logic           packet_ready,
    output period_t        timings_o,
    output logic [3:0]     ch0,
    output logic [3:0]     ch1,
    output logic [3:0]     ch2
);
    localparam logic [23:0] NullHeader = 24'h000000;

    function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
        return (e >> 1) ^ ((e[0] ^ b) ? 8'b1000_0011 : 8'h00);
    endfunction

    logic [4:0]  r_pos;
    logic [23:0] r_hdr;
    logic [7:0]  r_hpar;
    logic [55:0] r_sub  [4];
    logic [7:0]  r_spar [4];
    period_t     r_tim;
    logic [3:0]  r_ch0, r_ch1, r_ch2;

    logic        w_active, w_load, w_hbit;
    logic [23:0] w_hdr, w_hdr_nxt;
    logic [7:0]  w_hpar_nxt;
    logic [55:0] w_sub      [4];
    logic [55:0] w_sub_nxt  [4];
    logic [7:0]  w_spar_nxt [4];
    logic [3:0]  w_even, w_odd;

    assign w_active     = (timings == DataIslandActive);
    assign w_load       = w_active && (r_pos == 5'd0);
    assign packet_ready = w_load && packet_valid && !rst;

    // On a load cycle the freshly offered (or null) packet is serialized directly, so bit 0 leaves without a bubble
    always_comb begin
        w_hdr      = w_load ? (packet_valid ? packet_header : NullHeader) : r_hdr;
        w_hdr_nxt  = w_hdr >> 1;
        w_hbit     = (r_pos < 5'd24) ? w_hdr[0] : r_hpar[r_pos[2:0]];
        w_hpar_nxt = (r_pos < 5'd24) ? bch_step(w_load ? 8'h00 : r_hpar, w_hdr[0]) : r_hpar;
        w_even     = '0;
        w_odd      = '0;
        for (int k = 0; k < 4; k++) begin
            w_sub[k]     = w_load ? (packet_valid ? packet_sub[56*k +: 56] : 56'd0) : r_sub[k];
            w_sub_nxt[k] = w_sub[k] >> 2;
            if (r_pos < 5'd28) begin
                w_even[k]     = w_sub[k][0];
                w_odd[k]      = w_sub[k][1];
                w_spar_nxt[k] = bch_step(bch_step(w_load ? 8'h00 : r_spar[k], w_sub[k][0]), w_sub[k][1]);
            end else begin
                w_even[k]     = r_spar[k][{r_pos[1:0], 1'b0}];
                w_odd[k]      = r_spar[k][{r_pos[1:0], 1'b1}];
                w_spar_nxt[k] = r_spar[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos  <= '0;
            r_hdr  <= '0;
            r_hpar <= '0;
            for (int k = 0; k < 4; k++) begin
                r_sub[k]  <= '0;
                r_spar[k] <= '0;
            end
            r_tim <= Control;
            r_ch0 <= '0;
            r_ch1 <= '0;
            r_ch2 <= '0;
        end else begin
            r_pos <= w_active ? r_pos + 5'd1 : 5'd0;
            r_tim <= timings;
            if (w_active) begin
                r_hdr  <= w_hdr_nxt;
                r_hpar <= w_hpar_nxt;
                for (int k = 0; k < 4; k++) begin
                    r_sub[k]  <= w_sub_nxt[k];
                    r_spar[k] <= w_spar_nxt[k];
                end
                r_ch0 <= {r_pos != 5'd0, w_hbit, vsync, hsync};
                r_ch1 <= w_even;
                r_ch2 <= w_odd;
            end else begin
                r_ch0 <= {2'b00, vsync, hsync};
                r_ch1 <= '0;
                r_ch2 <= '0;
            end
        end
    end

`ifdef H14TX_PACKETIZER_OUTREG_EN
    period_t    r_tim_q;
    logic [3:0] r_ch0_q, r_ch1_q, r_ch2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tim_q <= Control;
            r_ch0_q <= '0;
            r_ch1_q <= '0;
            r_ch2_q <= '0;
        end else begin
            r_tim_q <= r_tim;
            r_ch0_q <= r_ch0;
            r_ch1_q <= r_ch1;
            r_ch2_q <= r_ch2;
        end
    end

    assign timings_o = r_tim_q;
    assign ch0       = r_ch0_q;
    assign ch1       = r_ch1_q;
    assign ch2       = r_ch2_q;
`else
    assign timings_o = r_tim;
    assign ch0       = r_ch0;
    assign ch1       = r_ch1;
    assign ch2       = r_ch2;
`endif

endmodule

// File: tb/tb_h14tx_island_packetizer.sv
// Directed self-checking bench for h14tx_island_packetizer (honours H14TX_PACKETIZER_OUTREG_EN latency).
`timescale 1ns/1ps
module tb_h14tx_island_packetizer;
    import h14tx_pkg::*;

`ifdef H14TX_PACKETIZER_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    period_t      timings;
    logic         hsync, vsync, packet_valid;
    logic [23:0]  packet_header;
    logic [223:0] packet_sub;
    logic         packet_ready;
    period_t      timings_o;
    logic [3:0]   ch0, ch1, ch2;

    h14tx_island_packetizer dut (
        .clk(clk), .rst(rst), .timings(timings), .hsync(hsync), .vsync(vsync),
        .packet_valid(packet_valid), .packet_header(packet_header), .packet_sub(packet_sub),
        .packet_ready(packet_ready), .timings_o(timings_o), .ch0(ch0), .ch1(ch1), .ch2(ch2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Output history indexed by the input cycle that produced it (latency already removed)
    period_t    ot [0:4095];
    logic [3:0] o0 [0:4095];
    logic [3:0] o1 [0:4095];
    logic [3:0] o2 [0:4095];
    logic       rd [0:4095];
    logic       ihs[0:4095];
    logic       ivs[0:4095];

    // Reference slot streams
    logic       m_h [0:31];
    logic [3:0] m_c1[0:31];
    logic [3:0] m_c2[0:31];

    logic [23:0]  b2b_hdr[0:17];
    logic [223:0] b2b_sub[0:17];

    localparam logic [223:0] AVI_SUB = {56'h00000000000000, 56'h0000000000A0C1,
                                        56'h00000000000004, 56'h00001008285F91};

    function automatic logic [7:0] ref_bch(input logic [7:0] e, input logic b);
        logic [7:0] n;
        n = {1'b0, e[7:1]};
        if (e[0] != b) n = n ^ 8'h83;
        return n;
    endfunction

    task automatic build_model(input logic [23:0] hdr, input logic [223:0] sub);
        logic [7:0] e;
        e = 8'h00;
        for (int i = 0; i < 24; i++) begin
            m_h[i] = hdr[i];
            e = ref_bch(e, hdr[i]);
        end
        for (int i = 0; i < 8; i++) m_h[24+i] = e[i];
        for (int k = 0; k < 4; k++) begin
            e = 8'h00;
            for (int p = 0; p < 28; p++) begin
                m_c1[p][k] = sub[56*k + 2*p];
                m_c2[p][k] = sub[56*k + 2*p + 1];
                e = ref_bch(e, sub[56*k + 2*p]);
                e = ref_bch(e, sub[56*k + 2*p + 1]);
            end
            for (int q = 0; q < 4; q++) begin
                m_c1[28+q][k] = e[2*q];
                m_c2[28+q][k] = e[2*q+1];
            end
        end
    endtask

    function automatic logic [14:0] exp_act(input int p, input logic hs, input logic vs);
        return {DataIslandActive, (p != 0), m_h[p], vs, hs, m_c1[p], m_c2[p]};
    endfunction

    function automatic logic [14:0] exp_ctl(input period_t t, input logic hs, input logic vs);
        return {t, 2'b00, vs, hs, 8'h00};
    endfunction

    function automatic logic [14:0] obs(input int c);
        return {ot[c], o0[c], o1[c], o2[c]};
    endfunction

    task automatic step(input period_t t, input logic hs, input logic vs, input logic pv);
        timings = t; hsync = hs; vsync = vs; packet_valid = pv;
        ihs[cyc] = hs; ivs[cyc] = vs;
        #1;
        rd[cyc] = packet_ready;
        @(posedge clk); #1;
        if (cyc >= LAT - 1) begin
            ot[cyc-LAT+1] = timings_o;
            o0[cyc-LAT+1] = ch0;
            o1[cyc-LAT+1] = ch1;
            o2[cyc-LAT+1] = ch2;
        end
        cyc++;
    endtask

    task automatic test_reset;
        rst = 1'b1; timings = DataIslandActive; hsync = 1'b1; vsync = 1'b1;
        packet_valid = 1'b1; packet_header = 24'h0D0282; packet_sub = AVI_SUB;
        #2;
        checks++;
        if (packet_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", packet_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({timings_o, ch0, ch1, ch2} !== {Control, 12'h000}) begin
            errors++; $display("FAIL reset_outputs: got tim=%0d ch=%h/%h/%h want tim=0 ch=0/0/0", timings_o, ch0, ch1, ch2);
        end
        checks++;
        if (packet_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_held: got %b want 0", packet_ready);
        end
        timings = Control;
        rst = 1'b0;
    endtask

    task automatic test_idle;
        int s0, nrdy;
        s0 = cyc; nrdy = 0;
        for (int i = 0; i < 100 + LAT; i++) step(Control, 1'b1, 1'b0, 1'b1);
        for (int c = s0; c < s0 + 100; c++) begin
            checks++;
            if (obs(c) !== {Control, 4'b0001, 8'h00}) begin
                errors++; $display("FAIL idle c=%0d: got %h want %h", c - s0, obs(c), {Control, 4'b0001, 8'h00});
            end
            if (rd[c]) nrdy++;
        end
        checks++;
        if (nrdy !== 0) begin
            errors++; $display("FAIL idle_ready: got %0d accepts want 0", nrdy);
        end
    endtask

    task automatic test_single_packet;
        int s0, nrdy;
        logic [7:0] par;
        packet_header = 24'h0D0282; packet_sub = AVI_SUB;
        s0 = cyc; nrdy = 0;
        for (int p = 0; p < 64; p++) step(DataIslandActive, p[0], p[3], p == 0);
        step(Control, 1'b1, 1'b1, 1'b0);
        step(Control, 1'b0, 1'b0, 1'b0);
        for (int c = s0; c < s0 + 64; c++) if (rd[c]) nrdy++;
        checks++;
        if (rd[s0] !== 1'b1 || nrdy !== 1) begin
            errors++; $display("FAIL single_accept: got first=%b count=%0d want first=1 count=1", rd[s0], nrdy);
        end
        build_model(24'h0D0282, AVI_SUB);
        for (int p = 0; p < 32; p++) begin
            checks++;
            if (obs(s0+p) !== exp_act(p, ihs[s0+p], ivs[s0+p])) begin
                errors++; $display("FAIL single_slot0 p=%0d: got %h want %h", p, obs(s0+p), exp_act(p, ihs[s0+p], ivs[s0+p]));
            end
        end
        for (int i = 0; i < 8; i++) par[i] = o0[s0+24+i][2];
        checks++;
        if (par !== 8'hE4) begin
            errors++; $display("FAIL single_hdr_parity: got %h want e4", par);
        end
        build_model(24'h000000, 224'd0);
        for (int p = 0; p < 32; p++) begin
            checks++;
            if (obs(s0+32+p) !== exp_act(p, ihs[s0+32+p], ivs[s0+32+p])) begin
                errors++; $display("FAIL single_slot1_null p=%0d: got %h want %h", p, obs(s0+32+p), exp_act(p, ihs[s0+32+p], ivs[s0+32+p]));
            end
        end
        checks++;
        if (obs(s0+64) !== exp_ctl(Control, 1'b1, 1'b1)) begin
            errors++; $display("FAIL single_after: got %h want %h", obs(s0+64), exp_ctl(Control, 1'b1, 1'b1));
        end
    endtask

    task automatic test_null_fill;
        int s0, nrdy;
        packet_header = 24'hFFFFFF; packet_sub = {224{1'b1}};
        s0 = cyc; nrdy = 0;
        for (int p = 0; p < 64; p++) step(DataIslandActive, p[1], p[2], 1'b0);
        step(Control, 1'b0, 1'b0, 1'b0);
        step(Control, 1'b0, 1'b0, 1'b0);
        build_model(24'h000000, 224'd0);
        for (int c = s0; c < s0 + 64; c++) begin
            if (rd[c]) nrdy++;
            checks++;
            if (obs(c) !== exp_act((c - s0) % 32, ihs[c], ivs[c])) begin
                errors++; $display("FAIL null_fill c=%0d: got %h want %h", c - s0, obs(c), exp_act((c - s0) % 32, ihs[c], ivs[c]));
            end
        end
        checks++;
        if (nrdy !== 0) begin
            errors++; $display("FAIL null_ready: got %0d accepts want 0", nrdy);
        end
    endtask

    task automatic test_back_to_back;
        int s0, nrdy;
        s0 = cyc; nrdy = 0;
        for (int n = 0; n < 18; n++) begin
            b2b_hdr[n] = {8'(n + 1), 8'h02, 8'h84};
            b2b_sub[n] = {7{32'(n + 1) * 32'h9E3779B9}};
            packet_header = b2b_hdr[n];
            packet_sub    = b2b_sub[n];
            for (int p = 0; p < 32; p++) step(DataIslandActive, p[0], 1'b1, 1'b1);
        end
        step(Control, 1'b0, 1'b1, 1'b0);
        step(Control, 1'b0, 1'b1, 1'b0);
        for (int c = s0; c < s0 + 576; c++) if (rd[c]) nrdy++;
        checks++;
        if (nrdy !== 18) begin
            errors++; $display("FAIL b2b_count: got %0d accepts want 18", nrdy);
        end
        for (int n = 0; n < 18; n++) begin
            checks++;
            if (rd[s0 + 32*n] !== 1'b1) begin
                errors++; $display("FAIL b2b_accept slot=%0d: got %b want 1", n, rd[s0 + 32*n]);
            end
            build_model(b2b_hdr[n], b2b_sub[n]);
            for (int p = 0; p < 32; p++) begin
                checks++;
                if (obs(s0 + 32*n + p) !== exp_act(p, ihs[s0 + 32*n + p], 1'b1)) begin
                    errors++; $display("FAIL b2b slot=%0d p=%0d: got %h want %h", n, p, obs(s0 + 32*n + p), exp_act(p, ihs[s0 + 32*n + p], 1'b1));
                end
            end
        end
    endtask

    task automatic test_truncated;
        int s0, s1, nrdy;
        packet_header = 24'hABCDEF; packet_sub = {4{56'h0123456789ABCD}};
        s0 = cyc;
        for (int p = 0; p < 10; p++) step(DataIslandActive, 1'b1, p[0], 1'b1);
        for (int i = 0; i < 3; i++) step(Control, 1'b0, 1'b1, 1'b1);
        build_model(24'hABCDEF, {4{56'h0123456789ABCD}});
        for (int p = 0; p < 10; p++) begin
            checks++;
            if (obs(s0+p) !== exp_act(p, 1'b1, ivs[s0+p])) begin
                errors++; $display("FAIL trunc_partial p=%0d: got %h want %h", p, obs(s0+p), exp_act(p, 1'b1, ivs[s0+p]));
            end
        end
        checks++;
        if (obs(s0+10) !== exp_ctl(Control, 1'b0, 1'b1)) begin
            errors++; $display("FAIL trunc_revert: got %h want %h", obs(s0+10), exp_ctl(Control, 1'b0, 1'b1));
        end
        packet_header = 24'h13579B; packet_sub = {4{56'hFEDCBA98765432}};
        s1 = cyc; nrdy = 0;
        for (int p = 0; p < 32; p++) step(DataIslandActive, p[2], 1'b0, p == 0);
        step(Control, 1'b0, 1'b0, 1'b0);
        for (int c = s1; c < s1 + 32; c++) if (rd[c]) nrdy++;
        checks++;
        if (rd[s1] !== 1'b1 || nrdy !== 1) begin
            errors++; $display("FAIL trunc_reaccept: got first=%b count=%0d want first=1 count=1", rd[s1], nrdy);
        end
        build_model(24'h13579B, {4{56'hFEDCBA98765432}});
        for (int p = 0; p < 32; p++) begin
            checks++;
            if (obs(s1+p) !== exp_act(p, ihs[s1+p], 1'b0)) begin
                errors++; $display("FAIL trunc_next p=%0d: got %h want %h", p, obs(s1+p), exp_act(p, ihs[s1+p], 1'b0));
            end
        end
    endtask

    task automatic test_reset_mid;
        int s0, s1;
        packet_header = 24'h5A0C33; packet_sub = {4{56'h00FF00FF00FF00}};
        s0 = cyc;
        for (int p = 0; p < 15; p++) step(DataIslandActive, p[0], 1'b0, p == 0);
        build_model(24'h5A0C33, {4{56'h00FF00FF00FF00}});
        for (int p = 0; p < 15 - (LAT - 1); p++) begin
            checks++;
            if (obs(s0+p) !== exp_act(p, ihs[s0+p], 1'b0)) begin
                errors++; $display("FAIL rstmid_pre p=%0d: got %h want %h", p, obs(s0+p), exp_act(p, ihs[s0+p], 1'b0));
            end
        end
        timings = DataIslandActive; packet_valid = 1'b1; hsync = 1'b1; vsync = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({timings_o, ch0, ch1, ch2, packet_ready} !== {Control, 12'h000, 1'b0}) begin
            errors++; $display("FAIL rstmid_async: got tim=%0d ch=%h/%h/%h rdy=%b want 0/0/0/0 rdy=0", timings_o, ch0, ch1, ch2, packet_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({timings_o, ch0, ch1, ch2, packet_ready} !== {Control, 12'h000, 1'b0}) begin
                errors++; $display("FAIL rstmid_hold i=%0d: got tim=%0d ch=%h/%h/%h rdy=%b", i, timings_o, ch0, ch1, ch2, packet_ready);
            end
        end
        rst = 1'b0;
        packet_header = 24'h0D0282; packet_sub = AVI_SUB;
        s1 = cyc;
        for (int p = 0; p < 32; p++) step(DataIslandActive, 1'b0, p[1], p == 0);
        step(Control, 1'b1, 1'b0, 1'b0);
        step(Control, 1'b1, 1'b0, 1'b0);
        checks++;
        if (rd[s1] !== 1'b1) begin
            errors++; $display("FAIL rstmid_accept: got %b want 1", rd[s1]);
        end
        build_model(24'h0D0282, AVI_SUB);
        for (int p = 0; p < 32; p++) begin
            checks++;
            if (obs(s1+p) !== exp_act(p, 1'b0, ivs[s1+p])) begin
                errors++; $display("FAIL rstmid_post p=%0d: got %h want %h", p, obs(s1+p), exp_act(p, 1'b0, ivs[s1+p]));
            end
        end
        checks++;
        if (obs(s1+32) !== exp_ctl(Control, 1'b1, 1'b0)) begin
            errors++; $display("FAIL rstmid_after: got %h want %h", obs(s1+32), exp_ctl(Control, 1'b1, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_idle();
        test_single_packet();
        test_null_fill();
        test_back_to_back();
        test_truncated();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
